// File: rtl/mult_err_accum.sv
// mult_err_accum: exact-vs-approximate multiplier error accumulator; define ERR_SIGNED_SUM_EN to add the signed sum_ed output
module mult_err_accum #(
    parameter int N_SAMPLES = 10000,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] exact,
    input  logic [W-1:0] apprx,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sample_cnt,
    output logic [31:0]  err_cnt,
    output logic [39:0]  sum_ed_abs,
    output logic [W-1:0] max_ed
`ifdef ERR_SIGNED_SUM_EN
    ,
    output logic signed [40:0] sum_ed
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic clr, acc, last;
    logic signed [W:0] diff;
    logic [W-1:0] ed_abs;
    always_comb begin
        in_ready = state == RUN;
        busy     = state == RUN;
        done     = state == DONE;
        clr      = start && state != RUN;
        acc      = in_valid && state == RUN;
        last     = sample_cnt == 32'(N_SAMPLES - 1);
        diff     = signed'({1'b0, exact} - {1'b0, apprx});
        ed_abs   = W'(diff[W] ? -diff : diff);
        state_n  = clr ? RUN : (acc && last) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed_abs <= '0;
            max_ed     <= '0;
`ifdef ERR_SIGNED_SUM_EN
            sum_ed     <= '0;
`endif
        end else begin
            state <= state_n;
            if (clr) begin
                sample_cnt <= '0;
                err_cnt    <= '0;
                sum_ed_abs <= '0;
                max_ed     <= '0;
`ifdef ERR_SIGNED_SUM_EN
                sum_ed     <= '0;
`endif
            end else if (acc) begin
                sample_cnt <= sample_cnt + 32'd1;
                err_cnt    <= (exact != apprx) ? err_cnt + 32'd1 : err_cnt;
                sum_ed_abs <= sum_ed_abs + 40'(ed_abs);
                max_ed     <= (ed_abs > max_ed) ? ed_abs : max_ed;
`ifdef ERR_SIGNED_SUM_EN
                sum_ed     <= sum_ed + 41'(diff);
`endif
            end
        end
    end
endmodule

// File: tb/tb_mult_err_accum.sv
// tb_mult_err_accum: randomized and directed checks of mult_err_accum against an arithmetic reference model
module tb_mult_err_accum;
    localparam int N = 4;
    localparam int W = 16;
    logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [W-1:0] exact = '0, apprx = '0;
    logic in_ready, busy, done;
    logic [31:0] sample_cnt, err_cnt;
    logic [39:0] sum_ed_abs;
    logic [W-1:0] max_ed;
`ifdef ERR_SIGNED_SUM_EN
    logic signed [40:0] sum_ed;
`endif
    int ncmp = 0, nfail = 0;
    longint m_cnt, m_err, m_sum, m_max, m_sed;

    mult_err_accum #(.N_SAMPLES(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .exact(exact), .apprx(apprx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .sum_ed_abs(sum_ed_abs), .max_ed(max_ed)
`ifdef ERR_SIGNED_SUM_EN
        , .sum_ed(sum_ed)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_totals(input string tag);
        chk({tag, ".sample_cnt"}, 64'(sample_cnt), m_cnt);
        chk({tag, ".err_cnt"}, 64'(err_cnt), m_err);
        chk({tag, ".sum_ed_abs"}, 64'(sum_ed_abs), m_sum);
        chk({tag, ".max_ed"}, 64'(max_ed), m_max);
`ifdef ERR_SIGNED_SUM_EN
        chk({tag, ".sum_ed"}, {{23{sum_ed[40]}}, sum_ed}, m_sed);
`endif
    endtask

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sed = 0;
    endtask

    // Presents a pair during start; it must not be counted.
    task automatic begin_run();
        start = 1; in_valid = 1;
        exact = W'($urandom); apprx = W'($urandom);
        @(posedge clk); #1;
        start = 0; in_valid = 0;
        model_clear();
        chk("start.busy", 64'(busy), 1);
        chk("start.in_ready", 64'(in_ready), 1);
        chk("start.done", 64'(done), 0);
        chk_totals("start");
    endtask

    task automatic send(input logic [W-1:0] e, input logic [W-1:0] a, input int gap, input logic st);
        longint ed;
        for (int g = 0; g < gap; g++) begin
            in_valid = 0; exact = W'($urandom); apprx = W'($urandom);
            @(posedge clk); #1;
            chk("gap.sample_cnt", 64'(sample_cnt), m_cnt);
            chk("gap.done", 64'(done), 0);
        end
        in_valid = 1; exact = e; apprx = a; start = st;
        @(posedge clk); #1;
        in_valid = 0; start = 0;
        ed = (e > a) ? longint'(e) - longint'(a) : longint'(a) - longint'(e);
        m_cnt++;
        if (e != a) m_err++;
        m_sum += ed;
        if (ed > m_max) m_max = ed;
        m_sed += longint'(e) - longint'(a);
        chk_totals("acc");
        chk("acc.done", 64'(done), 64'(m_cnt == N));
        chk("acc.busy", 64'(busy), 64'(m_cnt != N));
    endtask

    initial begin
        logic [W-1:0] v;
        logic [15:0] de[4] = '{16'd100, 16'd50, 16'd0, 16'd65025};
        logic [15:0] da[4] = '{16'd90, 16'd60, 16'd0, 16'd64000};
        model_clear();
        #2;
        chk("rst.busy", 64'(busy), 0);
        chk("rst.in_ready", 64'(in_ready), 0);
        chk("rst.done", 64'(done), 0);
        chk_totals("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        in_valid = 1; exact = 16'd7; apprx = 16'd3;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        chk("idle.sample_cnt", 64'(sample_cnt), 0);
        chk("idle.busy", 64'(busy), 0);
        // equal pairs
        begin_run();
        for (int i = 0; i < N; i++) begin
            v = W'($urandom);
            send(v, v, 0, 0);
        end
        chk("eq.err_cnt", 64'(err_cnt), 0);
        chk("eq.sum", 64'(sum_ed_abs), 0);
        chk("eq.in_ready", 64'(in_ready), 0);
        // directed pairs, back to back then with gaps
        for (int pass = 0; pass < 2; pass++) begin
            begin_run();
            for (int i = 0; i < N; i++) send(de[i], da[i], pass * (i + 1), 0);
            chk("dir.err_cnt", 64'(err_cnt), 3);
            chk("dir.sum", 64'(sum_ed_abs), 1045);
            chk("dir.max", 64'(max_ed), 1025);
`ifdef ERR_SIGNED_SUM_EN
            chk("dir.sum_ed", {{23{sum_ed[40]}}, sum_ed}, 1025);
`endif
        end
        // start during RUN is ignored and the pair counts
        begin_run();
        send(16'd500, 16'd400, 0, 0);
        send(16'd10, 16'd30, 1, 0);
        send(16'd40, 16'd40, 0, 1);
        send(16'd1, 16'd65535, 0, 0);
        // reset mid-run
        begin_run();
        send(16'd9, 16'd2, 0, 0);
        send(16'd3, 16'd8, 0, 0);
        #2 rst_n = 0;
        #1;
        model_clear();
        chk("mrst.busy", 64'(busy), 0);
        chk("mrst.in_ready", 64'(in_ready), 0);
        chk("mrst.done", 64'(done), 0);
        chk_totals("mrst");
        @(posedge clk); #1 rst_n = 1;
        in_valid = 1;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        chk("mrst.nostart", 64'(sample_cnt), 0);
        chk("mrst.idle_busy", 64'(busy), 0);
        // random runs, mixing equal, near and far pairs
        for (int r = 0; r < 8; r++) begin
            begin_run();
            for (int i = 0; i < N; i++) begin
                v = W'($urandom);
                case ($urandom_range(0, 3))
                    0: send(v, v, $urandom_range(0, 2), 0);
                    1: send(v, v ^ W'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
                    default: send(v, W'($urandom), $urandom_range(0, 2), 0);
                endcase
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mult_err_accum.md
MULT_ERR_ACCUM -- requirements
Module: mult_err_accum

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 10000, number of samples per measurement run (legal range 1 to 2^24).
REQ-002 SHALL have parameter W, default 16, product width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse that clears the accumulators and begins a run.
REQ-006 SHALL have port in_valid  input  1  exact/apprx pair is presented.
REQ-007 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-008 SHALL have port exact  input  W  exact product A*B.
REQ-009 SHALL have port apprx  input  W  approximate multiplier output.
REQ-010 SHALL have port busy  output  1  run in progress.
REQ-011 SHALL have port done  output  1  run complete; held until the next start or reset.
REQ-012 SHALL have port sample_cnt  output  32  accepted samples this run.
REQ-013 SHALL have port err_cnt  output  32  samples with exact != apprx.
REQ-014 SHALL have port sum_ed_abs  output  40  sum of |exact-apprx|.
REQ-015 SHALL have port max_ed  output  W  largest |exact-apprx| this run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready=1 only in RUN, busy=1 only in RUN, and done=1 only in DONE.
REQ-018 SHALL transition IDLE->RUN and DONE->RUN on start, zeroing all accumulators and counters in that same edge.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL accept a sample only on a cycle where in_valid && in_ready.
REQ-021 SHALL never accept a sample on the cycle start is sampled in IDLE or DONE.
REQ-022 SHALL compute ed_abs = |exact-apprx| as an unsigned W-bit value, using a W+1-bit difference internally.
REQ-023 SHALL, per accepted sample, increment sample_cnt, increment err_cnt if exact != apprx, and add ed_abs to sum_ed_abs.
REQ-024 SHALL update max_ed only when ed_abs > max_ed (strict greater-than).
REQ-025 SHALL make all accumulator outputs reflect an accepted sample one clock after acceptance.
REQ-026 SHALL, when the accepted sample makes sample_cnt reach N_SAMPLES, move to DONE on that edge, so in_ready=0 and done=1 on the next cycle with final totals.
REQ-027 SHALL hold the 40-bit sum without overflow for N_SAMPLES <= 2^24; no saturation logic is required.
REQ-028 SHALL not count cycles where in_valid=0 during RUN (gaps allowed).

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously, including mid-run), force state to IDLE and in_ready, busy, done, sample_cnt, err_cnt, sum_ed_abs, max_ed (and sum_ed) to 0.
REQ-030 SHALL require a fresh start after reset release before accepting samples.

Configuration
REQ-031 SHALL, with macro ERR_SIGNED_SUM_EN defined, add output sum_ed (signed 41-bit) accumulating signed exact-apprx per accepted sample, cleared like the other accumulators.
REQ-032 SHALL, without ERR_SIGNED_SUM_EN, omit the sum_ed port and its logic entirely; all other behaviour is unchanged.

Verification (N_SAMPLES=4, W=16)
REQ-033 SHALL verify: start, four pairs with exact=apprx -> err_cnt=0, sum_ed_abs=0, max_ed=0, sample_cnt=4, done=1 one cycle after the 4th accept.
REQ-034 SHALL verify: pairs (100,90), (50,60), (0,0), (65025,64000) -> err_cnt=3, sum_ed_abs=1045, max_ed=1025; with ERR_SIGNED_SUM_EN, sum_ed=1025.
REQ-035 SHALL verify: the same pairs with in_valid=0 gap cycles between them -> identical totals, with done asserted only after the 4th accepted pair.
REQ-036 SHALL verify: rst_n=0 after 2 accepts -> all outputs 0 and state IDLE; in_valid=1 without start -> sample_cnt stays 0.
REQ-037 SHALL verify: start pulsed in RUN -> no clear and the run continues; start in DONE -> totals zeroed, busy=1, and the pair presented on that cycle is not counted.
